// File: rtl/mnacidpro_pkg.sv
// Shared types and constants for the purification protocol sequencer.
package mnacidpro_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BEAD,
    LYSIS,
    WASH,
    ELUTE,
    DONE
  } step_e;

  localparam int NUM_VALVES = 11;

  // Bit positions of each pressure line inside the valve vector.
  localparam int V_LYSIS     = 0;
  localparam int V_WASH      = 1;
  localparam int V_ELUTE     = 2;
  localparam int V_DEAD_END  = 3;
  localparam int V_VERTICAL  = 4;
  localparam int V_HORIZ     = 5;
  localparam int V_WASTE     = 6;
  localparam int V_BEAD      = 7;
  localparam int V_LOOP_EXIT = 8;
  localparam int V_BEAD_TRAP = 9;
  localparam int V_COLLECT   = 10;

  localparam logic [NUM_VALVES-1:0] VALVE_ONE = NUM_VALVES'(1);

  // 1 = pressurized/closed; a step's vector clears the bits of the lines it opens.
  localparam logic [NUM_VALVES-1:0] VALVES_IDLE = '1;
  localparam logic [NUM_VALVES-1:0] VALVES_BEAD = VALVES_IDLE
    & ~(VALVE_ONE << V_BEAD) & ~(VALVE_ONE << V_VERTICAL)
    & ~(VALVE_ONE << V_BEAD_TRAP) & ~(VALVE_ONE << V_WASTE);
  localparam logic [NUM_VALVES-1:0] VALVES_LYSIS = VALVES_IDLE
    & ~(VALVE_ONE << V_LYSIS) & ~(VALVE_ONE << V_VERTICAL)
    & ~(VALVE_ONE << V_BEAD_TRAP) & ~(VALVE_ONE << V_WASTE);
  localparam logic [NUM_VALVES-1:0] VALVES_WASH = VALVES_IDLE
    & ~(VALVE_ONE << V_WASH) & ~(VALVE_ONE << V_HORIZ)
    & ~(VALVE_ONE << V_BEAD_TRAP) & ~(VALVE_ONE << V_WASTE);
  localparam logic [NUM_VALVES-1:0] VALVES_ELUTE = VALVES_IDLE
    & ~(VALVE_ONE << V_ELUTE) & ~(VALVE_ONE << V_HORIZ)
    & ~(VALVE_ONE << V_BEAD_TRAP) & ~(VALVE_ONE << V_LOOP_EXIT)
    & ~(VALVE_ONE << V_COLLECT);

  localparam logic [2:0] PUMP_REST = 3'b111;
  localparam logic [2:0] PUMP_PATTERN [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mnacidpro_pump_driver.sv
// 3-phase peristaltic pump driver: runs the 6-phase pattern for a given stroke count.
module mnacidpro_pump_driver
  import mnacidpro_pkg::*;
#(
  parameter int PHASE_CYCLES = 2,
  parameter int DW           = 3,
  parameter int SW           = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          abort,
  input  logic          run,
  input  logic [SW-1:0] strokes,
  output logic [2:0]    pump,
  output logic          stroke_done
);

  localparam logic [DW-1:0] DWELL_LOAD = DW'(PHASE_CYCLES - 1);

  logic          active;
  logic [DW-1:0] dwell;
  logic [2:0]    phase;
  logic [2:0]    phase_nx;
  logic [SW-1:0] stroke_left;

  assign phase_nx    = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
  // Asserted during the final clock of the final stroke so the sequencer can leave PUMP.
  assign stroke_done = active && (dwell == '0) && (phase == 3'd5) && (stroke_left == '0);

  // run means "the next cycle is a pump cycle"; the pattern is loaded on its rising edge.
  always_ff @(posedge clk) begin
    if (rst || abort || !run) begin
      active      <= 1'b0;
      dwell       <= '0;
      phase       <= 3'd0;
      stroke_left <= '0;
      pump        <= PUMP_REST;
    end else if (!active) begin
      active      <= 1'b1;
      dwell       <= DWELL_LOAD;
      phase       <= 3'd0;
      stroke_left <= strokes - 1'b1;
      pump        <= PUMP_PATTERN[0];
    end else if (dwell != '0) begin
      dwell <= dwell - 1'b1;
    end else begin
      dwell <= DWELL_LOAD;
      phase <= phase_nx;
      pump  <= PUMP_PATTERN[phase_nx];
      if (phase == 3'd5) stroke_left <= stroke_left - 1'b1;
    end
  end

endmodule

// File: rtl/mnacidpro_sequencer.sv
// Purification protocol sequencer: bead load, lysis, wash, then SIZE elutions.
//
// state | meaning
// IDLE  | all lines closed, waiting for start
// BEAD  | bead-load valve vector; settle then pump
// LYSIS | lysate-capture valve vector; settle then pump
// WASH  | wash valve vector; settle then pump
// ELUTE | elution into outlet elute_idx; settle then pump, repeated per outlet
// DONE  | one cycle, all closed, done pulse
module mnacidpro_sequencer
  import mnacidpro_pkg::*;
#(
  parameter int SIZE          = 5,
  parameter int SETTLE_CYCLES = 4,
  parameter int PHASE_CYCLES  = 2,
  parameter int BEAD_STROKES  = 4,
  parameter int LYSIS_STROKES = 8,
  parameter int WASH_STROKES  = 6,
  parameter int ELUTE_STROKES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            lysis_ctrl,
  output logic            wash_ctrl,
  output logic            elute_ctrl,
  output logic            dead_end_ctrl,
  output logic            vertical_ctrl,
  output logic            horiz_ctrl,
  output logic            waste_ctrl,
  output logic            bead_ctrl,
  output logic            loop_exit_ctrl,
  output logic            bead_trap_ctrl,
  output logic            collect_ctrl,
  output logic [2:0]      pump,
  output logic [SIZE-1:0] collect_sel,
  output logic            busy,
  output logic            done,
  output logic            aborted
);

  localparam int DW = $clog2(max_int(SETTLE_CYCLES, PHASE_CYCLES) + 1);
  localparam int SW = $clog2(max_int(max_int(BEAD_STROKES, LYSIS_STROKES),
                                     max_int(WASH_STROKES, ELUTE_STROKES)) + 1);
  localparam int EW = $clog2(SIZE + 1);

  localparam logic [DW-1:0]   SETTLE_LOAD = DW'(SETTLE_CYCLES - 1);
  localparam logic [EW-1:0]   ELUTE_LAST  = EW'(SIZE - 1);
  localparam logic [SIZE-1:0] SEL_ONE     = SIZE'(1);

  step_e                 step, step_n;
  logic                  pumping, pumping_n;
  logic [DW-1:0]         settle_cnt, settle_n;
  logic [EW-1:0]         elute_idx, elute_n;
  logic [NUM_VALVES-1:0] valves, valves_n;
  logic [SIZE-1:0]       sel_n;
  logic                  busy_n, done_n, aborted_n;
  logic                  run;
  logic [SW-1:0]         strokes;
  logic                  stroke_done;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      step        <= IDLE;
      pumping     <= 1'b0;
      settle_cnt  <= '0;
      elute_idx   <= '0;
      valves      <= VALVES_IDLE;
      collect_sel <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      step        <= step_n;
      pumping     <= pumping_n;
      settle_cnt  <= settle_n;
      elute_idx   <= elute_n;
      valves      <= valves_n;
      collect_sel <= sel_n;
      busy        <= busy_n;
      done        <= done_n;
      aborted     <= aborted_n;
    end
  end

  // Step sequencing, settle countdown, and next output values.
  always_comb begin
    step_n    = step;
    pumping_n = pumping;
    settle_n  = settle_cnt;
    elute_n   = elute_idx;
    done_n    = 1'b0;
    aborted_n = 1'b0;

    case (step)
      IDLE: begin
        if (start && !abort) begin
          step_n    = BEAD;
          pumping_n = 1'b0;
          settle_n  = SETTLE_LOAD;
        end
      end
      BEAD, LYSIS, WASH, ELUTE: begin
        if (!pumping) begin
          if (settle_cnt == '0) pumping_n = 1'b1;
          else                  settle_n  = settle_cnt - 1'b1;
        end else if (stroke_done) begin
          pumping_n = 1'b0;
          settle_n  = SETTLE_LOAD;
          case (step)
            BEAD:  step_n = LYSIS;
            LYSIS: step_n = WASH;
            WASH: begin
              step_n  = ELUTE;
              elute_n = '0;
            end
            default: begin
              if (elute_idx == ELUTE_LAST) begin
                step_n   = DONE;
                elute_n  = '0;
                settle_n = '0;
                done_n   = 1'b1;
              end else begin
                elute_n = elute_idx + 1'b1;
              end
            end
          endcase
        end
      end
      default: step_n = IDLE;
    endcase

    // Abort from any running state drops straight back to IDLE.
    if (abort && step != IDLE) begin
      step_n    = IDLE;
      pumping_n = 1'b0;
      settle_n  = '0;
      elute_n   = '0;
      done_n    = 1'b0;
      aborted_n = 1'b1;
    end

    valves_n = VALVES_IDLE;
    sel_n    = '0;
    strokes  = '0;
    case (step_n)
      BEAD: begin
        valves_n = VALVES_BEAD;
        strokes  = SW'(BEAD_STROKES);
      end
      LYSIS: begin
        valves_n = VALVES_LYSIS;
        strokes  = SW'(LYSIS_STROKES);
      end
      WASH: begin
        valves_n = VALVES_WASH;
        strokes  = SW'(WASH_STROKES);
      end
      ELUTE: begin
        valves_n = VALVES_ELUTE;
        sel_n    = SEL_ONE << elute_n;
        strokes  = SW'(ELUTE_STROKES);
      end
      default: ;
    endcase

    busy_n = (step_n != IDLE) && (step_n != DONE);
    run    = busy_n && pumping_n;
  end

  mnacidpro_pump_driver #(
    .PHASE_CYCLES(PHASE_CYCLES),
    .DW          (DW),
    .SW          (SW)
  ) u_pump (
    .clk        (clk),
    .rst        (rst),
    .abort      (abort),
    .run        (run),
    .strokes    (strokes),
    .pump       (pump),
    .stroke_done(stroke_done)
  );

  assign lysis_ctrl     = valves[V_LYSIS];
  assign wash_ctrl      = valves[V_WASH];
  assign elute_ctrl     = valves[V_ELUTE];
  assign dead_end_ctrl  = valves[V_DEAD_END];
  assign vertical_ctrl  = valves[V_VERTICAL];
  assign horiz_ctrl     = valves[V_HORIZ];
  assign waste_ctrl     = valves[V_WASTE];
  assign bead_ctrl      = valves[V_BEAD];
  assign loop_exit_ctrl = valves[V_LOOP_EXIT];
  assign bead_trap_ctrl = valves[V_BEAD_TRAP];
  assign collect_ctrl   = valves[V_COLLECT];

endmodule

// File: tb/tb_mnacidpro_sequencer.sv
// Directed bench for mnacidpro_sequencer with SIZE=2, SETTLE=4, PHASE=2, one stroke per step.
module tb_mnacidpro_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       lysis_ctrl, wash_ctrl, elute_ctrl, dead_end_ctrl, vertical_ctrl, horiz_ctrl;
  logic       waste_ctrl, bead_ctrl, loop_exit_ctrl, bead_trap_ctrl, collect_ctrl;
  logic [2:0] pump;
  logic [1:0] collect_sel;
  logic       busy, done, aborted;
  logic [10:0] valves;

  int total = 0;
  int bad   = 0;

  // Packed as {collect, bead_trap, loop_exit, bead, waste, horiz, vertical, dead_end, elute, wash, lysis}.
  localparam logic [10:0] V_IDLE = 11'h7FF;
  localparam logic [10:0] VEC [5] = '{11'h52F, 11'h5AE, 11'h59D, 11'h0DB, 11'h0DB};
  localparam logic [2:0]  PAT [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};

  assign valves = {collect_ctrl, bead_trap_ctrl, loop_exit_ctrl, bead_ctrl, waste_ctrl,
                   horiz_ctrl, vertical_ctrl, dead_end_ctrl, elute_ctrl, wash_ctrl, lysis_ctrl};

  mnacidpro_sequencer #(
    .SIZE(2), .SETTLE_CYCLES(4), .PHASE_CYCLES(2),
    .BEAD_STROKES(1), .LYSIS_STROKES(1), .WASH_STROKES(1), .ELUTE_STROKES(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lysis_ctrl(lysis_ctrl), .wash_ctrl(wash_ctrl), .elute_ctrl(elute_ctrl),
    .dead_end_ctrl(dead_end_ctrl), .vertical_ctrl(vertical_ctrl), .horiz_ctrl(horiz_ctrl),
    .waste_ctrl(waste_ctrl), .bead_ctrl(bead_ctrl), .loop_exit_ctrl(loop_exit_ctrl),
    .bead_trap_ctrl(bead_trap_ctrl), .collect_ctrl(collect_ctrl),
    .pump(pump), .collect_sel(collect_sel), .busy(busy), .done(done), .aborted(aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs k cycles after the start edge: steps are 16 cycles (4 settle + 12 pump).
  function automatic void expect_at(input int k, output logic [10:0] v, output logic [2:0] p,
                                    output logic [1:0] s, output logic b, output logic d);
    int st, j;
    v = V_IDLE; p = 3'b111; s = 2'b00; b = 1'b0; d = 1'b0;
    if (k >= 1 && k <= 80) begin
      st = (k - 1) / 16;
      j  = (k - 1) % 16;
      b  = 1'b1;
      v  = VEC[st];
      s  = (st == 3) ? 2'b01 : (st == 4) ? 2'b10 : 2'b00;
      p  = (j < 4) ? 3'b111 : PAT[(j - 4) / 2];
    end else if (k == 81) begin
      d = 1'b1;
    end
  endfunction

  // Pulse start, then check every output for cycles 1..last_k; optionally re-pulse start at restart_at.
  task automatic run_to(input int last_k, input int restart_at, output int busy_cnt);
    logic [10:0] v;
    logic [2:0]  p;
    logic [1:0]  s;
    logic        b, d;
    busy_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= last_k; k++) begin
      expect_at(k, v, p, s, b, d);
      chk_val($sformatf("k%0d valves", k), 32'(valves), 32'(v));
      chk_val($sformatf("k%0d pump", k), 32'(pump), 32'(p));
      chk_val($sformatf("k%0d sel", k), 32'(collect_sel), 32'(s));
      chk_val($sformatf("k%0d busy", k), 32'(busy), 32'(b));
      chk_val($sformatf("k%0d done", k), 32'(done), 32'(d));
      chk_val($sformatf("k%0d aborted", k), 32'(aborted), 32'(0));
      if (busy) busy_cnt++;
      start = (k == restart_at);
      if (k < last_k) tick();
    end
    start = 1'b0;
  endtask

  task automatic chk_idle(input string tag, input logic exp_aborted);
    chk_val({tag, " valves"}, 32'(valves), 32'(V_IDLE));
    chk_val({tag, " pump"}, 32'(pump), 32'(3'b111));
    chk_val({tag, " sel"}, 32'(collect_sel), 32'(0));
    chk_val({tag, " busy"}, 32'(busy), 32'(0));
    chk_val({tag, " done"}, 32'(done), 32'(0));
    chk_val({tag, " aborted"}, 32'(aborted), 32'(exp_aborted));
  endtask

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    #1;
    repeat (3) tick();
    chk_idle("reset", 1'b0);
    rst = 1'b0;
    tick();
    chk_idle("post_reset", 1'b0);

    // Full run, including the DONE pulse and return to IDLE.
    run_to(82, 0, cnt);
    chk_val("busy_cycles", 32'(cnt), 32'd80);
    tick();

    // Abort during WASH pumping (k=40), then restart at BEAD.
    run_to(40, 0, cnt);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort", 1'b1);
    tick();
    chk_idle("abort_after", 1'b0);
    run_to(5, 0, cnt);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort2", 1'b1);
    tick();

    // start and abort together in IDLE: nothing happens.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk_idle("start_abort", 1'b0);
    tick();
    chk_idle("start_abort2", 1'b0);

    // start during LYSIS is ignored; timing identical to a clean run.
    run_to(82, 20, cnt);
    chk_val("busy_cycles_restart", 32'(cnt), 32'd80);
    tick();

    // Reset during ELUTE 1 pumping (k=70).
    run_to(70, 0, cnt);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rst_mid", 1'b0);
    tick();
    chk_idle("rst_mid2", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mnacidpro_sequencer.md
# mnacidpro_sequencer

Protocol sequencer for the nucleic-acid purification chip. It drives the valve-control and 3-phase pump pads of the padded purification top level through a fixed protocol: bead load, lysate capture, wash, then SIZE elutions into separate collect outlets. It sits between the host/test controller (start/abort) and the pneumatic control pads, with each control bit mapped one-to-one to a pressure line.

## Interface
Parameters:
- SIZE, 5, number of elution/collect outlets (≥1)
- SETTLE_CYCLES, 4, valve actuation dwell before pumping in each step (≥1)
- PHASE_CYCLES, 2, clocks each pump phase is held (≥1)
- BEAD_STROKES, 4, pump strokes in the bead-load step (≥1)
- LYSIS_STROKES, 8, pump strokes in the lysis step (≥1)
- WASH_STROKES, 6, pump strokes in the wash step (≥1)
- ELUTE_STROKES, 2, pump strokes per elution (≥1)

Ports:
- clk in 1 — single clock
- rst in 1 — synchronous, active-high reset
- start in 1 — begin protocol; sampled only in IDLE
- abort in 1 — terminate the protocol immediately
- lysis_ctrl, wash_ctrl, elute_ctrl, dead_end_ctrl, vertical_ctrl, horiz_ctrl, waste_ctrl, bead_ctrl, loop_exit_ctrl, bead_trap_ctrl, collect_ctrl out 1 each — valve pressure, 1 = pressurized/closed
- pump out 3 — peristaltic pump valves, 1 = closed
- collect_sel out SIZE — one-hot outlet select during elution, else 0
- busy out 1 — protocol running
- done out 1 — one-cycle pulse on normal completion
- aborted out 1 — one-cycle pulse on abort

## Operation
- All outputs are registered. Reset and IDLE values: all 11 valve ctrls = 1, pump = 3'b111, collect_sel = 0, busy/done/aborted = 0.
- Step order: BEAD → LYSIS → WASH → ELUTE(0..SIZE-1) → DONE → IDLE.
- Each step has two sub-phases. SETTLE applies the step's valve vector with pump = 111 for SETTLE_CYCLES clocks. PUMP runs N strokes of the 6-phase pattern 011, 001, 101, 100, 110, 010, holding each phase PHASE_CYCLES clocks.
- Open valves per step (all others 1; dead_end_ctrl is always 1):
  - BEAD: bead, vertical, bead_trap, waste.
  - LYSIS: lysis, vertical, bead_trap, waste.
  - WASH: wash, horiz, bead_trap, waste.
  - ELUTE k: elute, horiz, bead_trap, loop_exit, collect; collect_sel = 1<<k.
- Each elution, including the first, has its own SETTLE.
- DONE: outputs return to IDLE values, done = 1 for one cycle, busy = 0.
- abort in any non-IDLE state: next cycle all outputs take IDLE values, aborted = 1 for one cycle, all counters clear, state = IDLE.
- abort in IDLE has no effect. start and abort in the same IDLE cycle: abort wins and nothing starts.
- start while busy is ignored.
- rst mid-protocol behaves like abort but without the aborted pulse.

## Timing
- start high at cycle t (in IDLE) → busy = 1 and BEAD valve vector on outputs at t+1.
- Step length = SETTLE_CYCLES + strokes·6·PHASE_CYCLES clocks. Pump = 111 on the first SETTLE cycle of the next step.
- Last elution ends at cycle e → DONE at e+1 (done = 1, busy = 0, all closed); IDLE at e+2. start is accepted again at e+2.
- Total busy cycles = (3+SIZE)·SETTLE_CYCLES + 6·PHASE_CYCLES·(BEAD+LYSIS+WASH+SIZE·ELUTE strokes).
- Counters: dwell counter sized $clog2(max(SETTLE_CYCLES,PHASE_CYCLES)+1); phase counter 0..5 wraps to 0 on each stroke; stroke counter sized for the max stroke parameter; elution index $clog2(SIZE+1).

## Structure
- Package mnacidpro_pkg holds:
  - step enum (IDLE, BEAD, LYSIS, WASH, ELUTE, DONE)
  - 11-bit valve-vector constants per step, with named bit indices
  - pump phase pattern array
  - constant PUMP_REST = 3'b111
- Sub-module mnacidpro_pump_driver handles the pump. Inputs: run, strokes, PHASE_CYCLES. Outputs: pump[2:0] and a one-cycle stroke_done at the end of the final stroke. It clears synchronously on rst or abort.
- The top-level FSM handles step sequencing, the settle counter and the elution index.

## Test plan
- Reset values: hold rst for 3 cycles, then check all ctrls = 1, pump = 111, collect_sel = 0, busy/done/aborted = 0.
- Full run (SIZE=2, SETTLE=4, PHASE=2, strokes 1/1/1/1): pulse start → busy for exactly 5·4 + 6·2·5 = 80 cycles. Check the valve vector per step and collect_sel = 01 then 10. The pump pattern repeats each 12 cycles. done pulses for one cycle.
- Pump pattern: in the BEAD PUMP sub-phase, check pump = 011,011,001,001,101,101,100,100,110,110,010,010, then 111 on entry to LYSIS SETTLE.
- Abort mid-WASH PUMP: next cycle all ctrls = 1, pump = 111, aborted = 1, busy = 0. A subsequent start restarts at BEAD.
- Simultaneous start+abort in IDLE → stays IDLE, no pulses. start during LYSIS → step timing is unchanged.
- rst asserted mid-ELUTE 1 → IDLE values next cycle, aborted stays 0, collect_sel = 0.
